// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size/state encodings and request legality check for the load/store unit.
//   SIZE_B/SIZE_H/SIZE_W : request size codes (2'b11 is illegal)
//   state_t              : ST_IDLE, ST_RD, ST_WR
//   bad_req()            : 1 when a size/offset pair is misaligned or illegal
package mem_access_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} state_t;
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   function automatic logic bad_req(input logic [1:0] off, input logic [1:0] size);
      return (size == 2'b11) || (size == SIZE_H && off[0]) || (size == SIZE_W && off != 2'b00);
   endfunction
endpackage

// File: rtl/mem_lane.sv
// mem_lane: combinational lane select/extend for loads and lane merge for sub-word stores.
//   word  : RAM word read back
//   off   : byte offset within the word
//   size  : access size code
//   uns   : zero-extend loads when set
//   wdata : right-aligned store data
//   ld    : extended load value
//   st    : word with the store lane replaced, other bytes kept
module mem_lane
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic [31:0] ld,
   output logic [31:0] st
);
   logic [31:0] shifted, mask, ins;
   logic [15:0] h;
   always_comb begin
      shifted = word >> {off, 3'b000};
      h       = off[1] ? word[31:16] : word[15:0];
      ld      = size == SIZE_B ? {{24{shifted[7] & ~uns}}, shifted[7:0]} :
                size == SIZE_H ? {{16{h[15] & ~uns}}, h} : word;
      // Replicating the store data puts it in every lane; the mask picks the target one.
      mask    = size == SIZE_B ? 32'h0000_00FF << {off, 3'b000} :
                size == SIZE_H ? (off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
      ins     = size == SIZE_B ? {4{wdata[7:0]}} :
                size == SIZE_H ? {2{wdata[15:0]}} : wdata;
      st      = (word & ~mask) | (ins & mask);
   end
endmodule

// File: rtl/mem_access.sv
// mem_access: byte-addressed load/store unit driving a single-port word RAM; sub-word stores use read-modify-write.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_we, req_addr, req_size    : store flag, byte address, size code
//   req_unsigned, req_wdata       : load zero-extend flag, right-aligned store data
//   resp_valid/resp_rdata/resp_err: registered one-cycle response
//   mem_addr/mem_din/mem_re/mem_we: RAM word address, write data, enables
//   mem_dout                      : RAM read data, one cycle after mem_re
module mem_access
   import mem_access_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_dout
);
   state_t state, state_nx;
   logic [31:0] a_addr, a_wdata, merged, ld_val, st_val;
   logic [1:0]  a_size;
   logic        a_uns, a_we, accept, err, wstore;

   assign req_ready = state == ST_IDLE;
   assign accept    = req_valid && req_ready;
   assign err       = bad_req(req_addr[1:0], req_size);
   assign wstore    = req_we && req_size == SIZE_W;

   mem_lane u_lane (
      .word  (mem_dout),
      .off   (a_addr[1:0]),
      .size  (a_size),
      .uns   (a_uns),
      .wdata (a_wdata),
      .ld    (ld_val),
      .st    (st_val)
   );

   always_comb begin
      state_nx = state;
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = a_addr[31:2];
      mem_din  = merged;
      case (state)
         ST_IDLE: begin
            mem_addr = req_addr[31:2];
            mem_din  = req_wdata;
            mem_re   = accept && !err && !wstore;
            mem_we   = accept && !err && wstore;
            state_nx = mem_re ? ST_RD : ST_IDLE;
         end
         ST_RD:   state_nx = a_we ? ST_WR : ST_IDLE;
         ST_WR: begin
            mem_we   = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         a_addr     <= '0;
         a_wdata    <= '0;
         a_size     <= '0;
         a_uns      <= 1'b0;
         a_we       <= 1'b0;
         merged     <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (mem_re) begin
            a_addr  <= req_addr;
            a_wdata <= req_wdata;
            a_size  <= req_size;
            a_uns   <= req_unsigned;
            a_we    <= req_we;
         end
         if (state == ST_RD) merged <= st_val;
         // Errors and word stores finish in the accept cycle; loads finish in RD, RMW stores in WR.
         resp_valid <= (accept && (err || wstore)) || (state == ST_RD && !a_we) || state == ST_WR;
         resp_err   <= accept && err;
         resp_rdata <= (state == ST_RD && !a_we) ? ld_val : '0;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven, hand-sequenced and random checks of mem_access against a byte-array reference model.
module tb_mem_access;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        resp_valid, resp_err, mem_re, mem_we;
   logic [31:0] resp_rdata, mem_din, mem_dout;
   logic [29:0] mem_addr;
   logic [31:0] ram [64];
   logic [7:0]  rb [256];
   int checks = 0, errors = 0;

   mem_access dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_re(mem_re), .mem_we(mem_we), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[5:0]] <= mem_din;
      if (mem_re) mem_dout <= ram[mem_addr[5:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: byte-addressed memory, little-endian, with the legality rules applied directly.
   task automatic model_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata,
                               output logic [31:0] rd, output logic err, output logic [31:0] word);
      int nb, a;
      logic [31:0] v;
      err = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
      nb  = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
      a   = int'(addr[7:0]);
      v   = '0;
      rd  = '0;
      if (!err && we)
         for (int i = 0; i < nb; i++) rb[(a + i) & 255] = wdata[8*i +: 8];
      else if (!err) begin
         for (int i = 0; i < nb; i++) v[8*i +: 8] = rb[(a + i) & 255];
         if (!uns && nb == 1 && v[7]) v = v | 32'hFFFF_FF00;
         if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
         rd = v;
      end
      a    = a & 252;
      word = {rb[a + 3], rb[a + 2], rb[a + 1], rb[a]};
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
   endtask

   task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] got, output logic gerr);
      logic [31:0] erd, ew, wdin;
      logic eerr;
      logic [4:0] re_m, we_m, ewe_m;
      int elat, lat;
      model_access(we, addr, size, uns, wdata, erd, eerr, ew);
      elat  = eerr ? 1 : (we && size == 2'd2) ? 1 : we ? 3 : 2;
      ewe_m = eerr ? 5'b0 : (we && size == 2'd2) ? 5'b00001 : we ? 5'b00100 : 5'b0;
      re_m = '0; we_m = '0; wdin = '0; got = '0; gerr = 1'b0; lat = 0;
      @(negedge clk);
      drive(we, addr, size, uns, wdata);
      #1;
      chk("req_ready_at_accept", 32'(req_ready), 32'd1);
      re_m[0] = mem_re; we_m[0] = mem_we;
      if (mem_we) wdin = mem_din;
      if (!eerr) chk("mem_addr", 32'(mem_addr), 32'(addr[31:2]));
      for (int k = 1; k <= 4 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         #1;
         re_m[k] = mem_re; we_m[k] = mem_we;
         if (mem_we) wdin = mem_din;
         if (resp_valid) begin
            lat = k; got = resp_rdata; gerr = resp_err;
         end
      end
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got no resp_valid within 4 cycles addr %h", addr);
      end
      chk("resp_latency", lat, elat);
      chk("resp_rdata", got, erd);
      chk("resp_err", 32'(gerr), 32'(eerr));
      chk("mem_re_cycles", 32'(re_m), (eerr || (we && size == 2'd2)) ? 32'd0 : 32'd1);
      chk("mem_we_cycles", 32'(we_m), 32'(ewe_m));
      if (ewe_m != 0) chk("mem_din", wdin, ew);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   initial begin
      vec_t tbl [12];
      logic [31:0] got, erd, ew, save;
      logic        gerr, eerr;
      for (int i = 0; i < 64; i++) ram[i] = $urandom;
      ram[4] = 32'h80FF_7F01;
      for (int i = 0; i < 256; i++) rb[i] = ram[i / 4][8*(i % 4) +: 8];

      tbl[0]  = '{1'b0, 32'h13, 2'd0, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0};
      tbl[1]  = '{1'b0, 32'h13, 2'd0, 1'b1, 32'h0,         32'h0000_0080, 1'b0};
      tbl[2]  = '{1'b0, 32'h10, 2'd1, 1'b0, 32'h0,         32'h0000_7F01, 1'b0};
      tbl[3]  = '{1'b0, 32'h12, 2'd1, 1'b0, 32'h0,         32'hFFFF_80FF, 1'b0};
      tbl[4]  = '{1'b1, 32'h11, 2'd0, 1'b0, 32'h1234_56AB, 32'h0,         1'b0};
      tbl[5]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,         32'h80FF_AB01, 1'b0};
      tbl[6]  = '{1'b0, 32'h12, 2'd1, 1'b1, 32'h0,         32'h0000_80FF, 1'b0};
      tbl[7]  = '{1'b1, 32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b0};
      tbl[8]  = '{1'b0, 32'h20, 2'd2, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tbl[9]  = '{1'b0, 32'h22, 2'd2, 1'b0, 32'h0,         32'h0,         1'b1};
      tbl[10] = '{1'b1, 32'h13, 2'd1, 1'b0, 32'h5555,      32'h0,         1'b1};
      tbl[11] = '{1'b0, 32'h14, 2'd3, 1'b0, 32'h0,         32'h0,         1'b1};

      repeat (2) @(negedge clk);
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_resp_err", 32'(resp_err), 32'd0);
      chk("reset_mem_en", {30'd0, mem_re, mem_we}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_req(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, got, gerr);
         chk($sformatf("tbl%0d_rdata", i), got, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d_err", i), 32'(gerr), 32'(tbl[i].exp_err));
      end
      chk("ram_after_sb", ram[4], 32'h80FF_AB01);

      // Word store immediately followed by a load accepted in the response cycle.
      @(negedge clk);
      drive(1'b1, 32'h24, 2'd2, 1'b0, 32'h0BAD_F00D);
      model_access(1'b1, 32'h24, 2'd2, 1'b0, 32'h0BAD_F00D, erd, eerr, ew);
      #1;
      chk("b2b_sw_we", 32'(mem_we), 32'd1);
      chk("b2b_sw_din", mem_din, 32'h0BAD_F00D);
      @(negedge clk);
      drive(1'b0, 32'h24, 2'd2, 1'b0, 32'h0);
      model_access(1'b0, 32'h24, 2'd2, 1'b0, 32'h0, erd, eerr, ew);
      #1;
      chk("b2b_sw_resp", 32'(resp_valid), 32'd1);
      chk("b2b_lw_ready", 32'(req_ready), 32'd1);
      chk("b2b_lw_re", 32'(mem_re), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("b2b_rd_ready", 32'(req_ready), 32'd0);
      chk("b2b_rd_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("b2b_lw_resp", 32'(resp_valid), 32'd1);
      chk("b2b_lw_rdata", resp_rdata, erd);

      // Load then sub-word store with req_valid held throughout.
      @(negedge clk);
      drive(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
      model_access(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, erd, eerr, ew);
      #1;
      chk("hold_lb_re", 32'(mem_re), 32'd1);
      @(negedge clk);
      drive(1'b1, 32'h12, 2'd0, 1'b0, 32'h0000_005A);
      #1;
      chk("hold_rd_ready", 32'(req_ready), 32'd0);
      chk("hold_rd_re", 32'(mem_re), 32'd0);
      @(negedge clk);
      #1;
      chk("hold_lb_resp", 32'(resp_valid), 32'd1);
      chk("hold_lb_rdata", resp_rdata, erd);
      chk("hold_sb_ready", 32'(req_ready), 32'd1);
      chk("hold_sb_re", 32'(mem_re), 32'd1);
      model_access(1'b1, 32'h12, 2'd0, 1'b0, 32'h0000_005A, erd, eerr, ew);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("hold_sb_rd_ready", 32'(req_ready), 32'd0);
      chk("hold_sb_rd_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      #1;
      chk("hold_sb_wr_ready", 32'(req_ready), 32'd0);
      chk("hold_sb_wr_we", 32'(mem_we), 32'd1);
      chk("hold_sb_wr_din", mem_din, ew);
      @(negedge clk);
      #1;
      chk("hold_sb_resp", 32'(resp_valid), 32'd1);
      chk("hold_sb_rdata", resp_rdata, 32'd0);

      // Reset asserted during the WR cycle of a half store: the write must not happen.
      save = ram[4];
      @(negedge clk);
      drive(1'b1, 32'h12, 2'd1, 1'b0, 32'h0000_1234);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_wr_we_before", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_wr_we_after", 32'(mem_we), 32'd0);
      chk("rst_wr_resp", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_wr_ram", ram[4], save);
      @(negedge clk);
      chk("rst_hold_resp", 32'(resp_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_release_ready", 32'(req_ready), 32'd1);
      chk("rst_release_resp", 32'(resp_valid), 32'd0);

      for (int n = 0; n < 150; n++) begin
         logic [1:0]  sz;
         logic [31:0] ad;
         sz = 2'($urandom_range(0, 3));
         ad = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) ad = sz == 2'd1 ? ad & ~32'd1 : sz == 2'd2 ? ad & ~32'd3 : ad;
         run_req(1'($urandom), ad, sz, 1'($urandom), $urandom, got, gerr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
